// File: rtl/window_builder.sv
`timescale 1ns/1ps
// Raster-order RGB pixels in, 3x3 grayscale neighbourhoods out. Two line buffers
// hold rows r-1 and r-2; a 3x3 shift window assembles columns c-2..c.
module window_builder #(
    parameter int MAX_WIDTH = 2500
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    input  logic [23:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] win_data,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        busy,
    output logic        done
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic logic [7:0] gray_f(input logic [23:0] rgb);
        logic [9:0] sum;
        sum = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
        return 8'(sum >> 2);
    endfunction

    state_t                   state_q, state_d;
    logic [15:0]              width_q, width_d;
    logic [15:0]              height_q, height_d;
    logic [15:0]              col_q, col_d;
    logic [15:0]              row_q, row_d;
    logic [0:2][0:2][7:0]     win_q, win_d;
    logic                     win_valid_q, win_valid_d;
    logic                     done_inv_q, done_inv_d;

    logic [7:0]               line1_q [MAX_WIDTH];
    logic [7:0]               line2_q [MAX_WIDTH];

    logic [AW-1:0]            col_idx;
    logic [7:0]               gray, l1_rd, l2_rd;
    logic                     accept, size_ok, last_col, last_row;

    assign col_idx  = col_q[AW-1:0];
    assign gray     = gray_f(pix_in);
    assign l1_rd    = line1_q[col_idx];
    assign l2_rd    = line2_q[col_idx];
    assign size_ok  = (img_width >= 16'd3) && (img_width <= 16'(MAX_WIDTH)) &&
                      (img_height >= 16'd3);
    assign last_col = (col_q == width_q - 16'd1);
    assign last_row = (row_q == height_q - 16'd1);

    assign pix_ready = (state_q == RUN) && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready && !start;
    assign win_valid = win_valid_q;
    assign win_data  = win_q;
    assign busy      = (state_q != IDLE);
    // Final-window done is combinational so it coincides with the accepting handshake.
    assign done      = !n_rst && (done_inv_q ||
                       (!start && (state_q == FLUSH) && win_valid_q && win_ready));

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        done_inv_d  = 1'b0;
        if (start) begin
            width_d     = img_width;
            height_d    = img_height;
            col_d       = '0;
            row_d       = '0;
            win_d       = '0;
            win_valid_d = 1'b0;
            if (size_ok) begin
                state_d = RUN;
            end else begin
                state_d    = IDLE;
                done_inv_d = 1'b1;
            end
        end else begin
            if (win_valid_q && win_ready) begin
                win_valid_d = 1'b0;
                if (state_q == FLUSH) state_d = IDLE;
            end
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win_d[i][0] = win_q[i][1];
                    win_d[i][1] = win_q[i][2];
                end
                win_d[0][2] = l2_rd;
                win_d[1][2] = l1_rd;
                win_d[2][2] = gray;
                win_valid_d = (row_q >= 16'd2) && (col_q >= 16'd2);
                if (last_col) begin
                    col_d = '0;
                    row_d = row_q + 16'd1;
                    if (last_row) state_d = FLUSH;
                end else begin
                    col_d = col_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            done_inv_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
            done_inv_q  <= done_inv_d;
        end
    end

    // Line buffers: reads above see the pre-edge contents, so rows shift down cleanly.
    always_ff @(posedge clk) begin
        if (accept) begin
            line1_q[col_idx] <= gray;
            line2_q[col_idx] <= l1_rd;
        end
    end

endmodule

// File: tb/tb_window_builder.sv
`timescale 1ns/1ps
// Scoreboard bench for window_builder: directed frames push expected windows,
// a negedge monitor pops and compares on every win_valid/win_ready handshake.
module tb_window_builder;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic [23:0] pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [71:0] win_data;
    logic        win_valid;
    logic        win_ready;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [71:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    bit          bp_mode = 1'b0;
    int          bp_cyc = 0;
    logic [71:0] held;
    bit          held_vld = 1'b0;
    int          d0;

    window_builder #(.MAX_WIDTH(2500)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: constant 1, or the repeating 1-0-0-1 stall pattern.
    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                win_ready = (bp_cyc % 4 == 0) || (bp_cyc % 4 == 3);
                bp_cyc++;
            end else begin
                win_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!n_rst) begin
            if (done) done_cnt++;
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_window: got %h want none", win_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("win_data", win_data, mon_e.data);
                    check("done_at_accept", done, mon_e.last);
                end
                held_vld = 1'b0;
            end else if (win_valid) begin
                check("pix_ready_in_stall", pix_ready, 0);
                if (held_vld) check("win_data_held", win_data, held);
                held     = win_data;
                held_vld = 1'b1;
            end else begin
                held_vld = 1'b0;
            end
        end
    end

    task automatic do_start(input logic [15:0] w, input logic [15:0] h);
        start      = 1'b1;
        img_width  = w;
        img_height = h;
        tick;
        start = 1'b0;
    endtask

    task automatic send_pixel(input logic [23:0] p, input bit chk);
        int n;
        pix_valid = 1'b1;
        pix_in    = p;
        n         = 0;
        @(negedge clk);
        if (chk) check("pix_ready_no_stall", pix_ready, 1);
        while (!pix_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) begin
            total++;
            bad++;
            $display("FAIL pixel_accept_timeout: got pix_ready=0 want 1 within 100 cycles");
        end
        tick;
    endtask

    task automatic drain;
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || win_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || win_valid) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        check("busy_after_frame", busy, 0);
        tick;
    endtask

    task automatic push(input logic [71:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic frame_5x4(input bit chk);
        logic [7:0] v;
        push(72'h0001020A0B0C141516, 1'b0);
        push(72'h0102030B0C0D151617, 1'b0);
        push(72'h0203040C0D0E161718, 1'b0);
        push(72'h0A0B0C1415161E1F20, 1'b0);
        push(72'h0B0C0D1516171F2021, 1'b0);
        push(72'h0C0D0E161718202122, 1'b1);
        do_start(16'd5, 16'd4);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                v = 8'(10 * r + c);
                send_pixel({v, v, v}, chk);
            end
        end
        pix_valid = 1'b0;
        drain();
    endtask

    initial begin
        n_rst      = 1'b1;
        start      = 1'b0;
        img_width  = '0;
        img_height = '0;
        pix_in     = 24'hFFFFFF;
        pix_valid  = 1'b1;

        // Reset held two cycles with pixels presented
        tick;
        tick;
        @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_data", win_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick;
        n_rst = 1'b0;
        tick;
        @(negedge clk);
        check("idle_pix_ready", pix_ready, 0);
        check("idle_win_valid", win_valid, 0);
        tick;
        pix_valid = 1'b0;
        check("rst_done_count", done_cnt, 0);

        // Gray conversion, 3x3 with green center
        d0 = done_cnt;
        push(72'h3F3F3F3F7F3F3F3F3F, 1'b1);
        do_start(16'd3, 16'd3);
        for (int i = 0; i < 9; i++)
            send_pixel((i == 4) ? 24'h00FF00 : 24'hFF0000, 1'b0);
        pix_valid = 1'b0;
        drain();
        check("gray_done_count", done_cnt - d0, 1);

        // Ordering, no backpressure
        d0 = done_cnt;
        frame_5x4(1'b1);
        check("order_done_count", done_cnt - d0, 1);

        // Backpressure 1-0-0-1
        d0      = done_cnt;
        bp_cyc  = 0;
        bp_mode = 1'b1;
        frame_5x4(1'b0);
        bp_mode = 1'b0;
        tick;
        check("bp_done_count", done_cnt - d0, 1);

        // Invalid size
        d0 = done_cnt;
        do_start(16'd2, 16'd10);
        @(negedge clk);
        check("inv_done_pulse", done, 1);
        check("inv_busy", busy, 0);
        tick;
        @(negedge clk);
        check("inv_done_low", done, 0);
        check("inv_busy_low", busy, 0);
        tick;
        check("inv_done_count", done_cnt - d0, 1);

        // Restart mid-frame
        d0 = done_cnt;
        do_start(16'd5, 16'd4);
        for (int i = 0; i < 7; i++) send_pixel(24'h505050, 1'b0);
        pix_valid = 1'b0;
        push(72'h010203040506070809, 1'b1);
        do_start(16'd3, 16'd3);
        for (int i = 1; i <= 9; i++) send_pixel({8'(i), 8'(i), 8'(i)}, 1'b0);
        pix_valid = 1'b0;
        drain();
        check("restart_done_count", done_cnt - d0, 1);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
